// File: rtl/m_pseq.sv
// Power sequencer: enables rails in ascending order on power-up and descending
// order on power-down, waits for power-good / discharge on each rail, bounds
// every wait with a tick-based timer, and latches faults until the request drops.
module m_pseq #(
  parameter int NR     = 4,
  parameter int T_TICK = 1000,
  parameter int T_PG   = 200,
  parameter int T_DLY  = 10,
  parameter int T_DIS  = 500,
  parameter int T_OFF  = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [NR-1:0] pg,
  input  logic [NR-1:0] dis,
  input  logic          ov,
  output logic [NR-1:0] en,
  output logic          pwr_ok,
  output logic          busy,
  output logic          fault,
  output logic [3:0]    flt_idx,
  output logic [1:0]    flt_type,
  output logic          warn
);

  localparam int IW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [IW-1:0] LAST = IW'(NR - 1);

  typedef enum logic [2:0] {
    S_OFF, S_UP_WAIT, S_UP_DLY, S_ON, S_DN_WAIT, S_DN_DLY, S_FAULT, S_COOL
  } state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [NR-1:0]  en_reg, en_next;
  logic           pwr_ok_reg, pwr_ok_next;
  logic           busy_reg, busy_next;
  logic           fault_reg, fault_next;
  logic [3:0]     flt_idx_reg, flt_idx_next;
  logic [1:0]     flt_type_reg, flt_type_next;
  logic           warn_reg, warn_next;

  logic [15:0]    presc_reg;
  logic           tick;
  logic [15:0]    tmr_reg;
  logic [15:0]    lim;
  logic           expired;
  logic [NR-1:0]  lost;
  logic           pg_lost;
  logic           take_fault;
  logic [1:0]     fault_kind;

  assign tick = (presc_reg == 16'(T_TICK - 1));

  // Free-running prescaler producing a one-clock tick every T_TICK cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else           presc_reg <= presc_reg + 16'd1;
  end

  // Limit of the state timer depends on what the current state is waiting for
  always_comb begin
    lim = 16'(T_DLY);
    case (state_reg)
      S_UP_WAIT: lim = 16'(T_PG);
      S_DN_WAIT: lim = 16'(T_DIS);
      S_COOL:    lim = 16'(T_OFF);
      default:   lim = 16'(T_DLY);
    endcase
  end

  assign expired = (tmr_reg >= lim);

  // State timer: restarts whenever the state or rail index moves, else counts ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                tmr_reg <= '0;
    else if ((state_next != state_reg) || (idx_next != idx_reg)) tmr_reg <= '0;
    else if (tick && (tmr_reg != 16'hFFFF))                    tmr_reg <= tmr_reg + 16'd1;
  end

  // A rail that is enabled and should already be good but has lost pg
  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_lost
      localparam logic [IW-1:0] J = IW'(gi);
      assign lost[gi] = en_reg[gi] & ~pg[gi] &
                        ((state_reg == S_UP_DLY) | (state_reg == S_ON) |
                         ((state_reg == S_UP_WAIT) & (J < idx_reg)));
    end
  endgenerate

  assign pg_lost = |lost;

  // Next-state and registered-output logic
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    en_next       = en_reg;
    pwr_ok_next   = pwr_ok_reg;
    fault_next    = fault_reg;
    flt_idx_next  = flt_idx_reg;
    flt_type_next = flt_type_reg;
    warn_next     = warn_reg;
    take_fault    = 1'b0;
    fault_kind    = 2'd0;

    case (state_reg)
      S_OFF: begin
        if (req) begin
          state_next  = S_UP_WAIT;
          idx_next    = '0;
          en_next     = '0;
          en_next[0]  = 1'b1;
          warn_next   = 1'b0;
        end
      end
      S_UP_WAIT: begin
        if (ov) begin
          take_fault = 1'b1; fault_kind = 2'd3;
        end else if (pg_lost) begin
          take_fault = 1'b1; fault_kind = 2'd2;
        end else if (pg[idx_reg]) begin
          // pg arriving on the expiry cycle still counts as success
          if (req) begin
            state_next = S_UP_DLY;
          end else begin
            state_next        = S_DN_WAIT;
            en_next[idx_reg]  = 1'b0;
          end
        end else if (expired) begin
          take_fault = 1'b1; fault_kind = 2'd1;
        end else if (!req) begin
          state_next        = S_DN_WAIT;
          en_next[idx_reg]  = 1'b0;
        end
      end
      S_UP_DLY: begin
        if (ov) begin
          take_fault = 1'b1; fault_kind = 2'd3;
        end else if (pg_lost) begin
          take_fault = 1'b1; fault_kind = 2'd2;
        end else if (!req) begin
          state_next        = S_DN_WAIT;
          en_next[idx_reg]  = 1'b0;
        end else if (expired) begin
          if (idx_reg == LAST) begin
            state_next  = S_ON;
            pwr_ok_next = 1'b1;
          end else begin
            state_next         = S_UP_WAIT;
            idx_next           = idx_reg + IW'(1);
            en_next[idx_next]  = 1'b1;
          end
        end
      end
      S_ON: begin
        if (ov) begin
          take_fault = 1'b1; fault_kind = 2'd3;
        end else if (pg_lost) begin
          take_fault = 1'b1; fault_kind = 2'd2;
        end else if (!req) begin
          state_next     = S_DN_WAIT;
          idx_next       = LAST;
          en_next[LAST]  = 1'b0;
          pwr_ok_next    = 1'b0;
        end
      end
      S_DN_WAIT: begin
        if (ov) begin
          take_fault = 1'b1; fault_kind = 2'd3;
        end else if (dis[idx_reg]) begin
          state_next = S_DN_DLY;
        end else if (expired) begin
          // A rail that never discharges is only a warning; keep shutting down
          warn_next  = 1'b1;
          state_next = S_DN_DLY;
        end
      end
      S_DN_DLY: begin
        if (ov) begin
          take_fault = 1'b1; fault_kind = 2'd3;
        end else if (expired) begin
          if (idx_reg != '0) begin
            state_next         = S_DN_WAIT;
            idx_next           = idx_reg - IW'(1);
            en_next[idx_next]  = 1'b0;
          end else begin
            state_next = S_COOL;
          end
        end
      end
      S_FAULT: begin
        en_next = '0;
        if (!req) state_next = S_COOL;
      end
      S_COOL: begin
        en_next = '0;
        if (expired) begin
          state_next    = S_OFF;
          fault_next    = 1'b0;
          flt_idx_next  = 4'd0;
          flt_type_next = 2'd0;
        end
      end
      default: state_next = S_OFF;
    endcase

    if (take_fault) begin
      state_next    = S_FAULT;
      idx_next      = idx_reg;
      en_next       = '0;
      pwr_ok_next   = 1'b0;
      fault_next    = 1'b1;
      flt_idx_next  = 4'(idx_reg);
      flt_type_next = fault_kind;
    end

    busy_next = (state_next == S_UP_WAIT) || (state_next == S_UP_DLY) ||
                (state_next == S_DN_WAIT) || (state_next == S_DN_DLY) ||
                (state_next == S_COOL);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_OFF;
      idx_reg      <= '0;
      en_reg       <= '0;
      pwr_ok_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      flt_idx_reg  <= 4'd0;
      flt_type_reg <= 2'd0;
      warn_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      en_reg       <= en_next;
      pwr_ok_reg   <= pwr_ok_next;
      busy_reg     <= busy_next;
      fault_reg    <= fault_next;
      flt_idx_reg  <= flt_idx_next;
      flt_type_reg <= flt_type_next;
      warn_reg     <= warn_next;
    end
  end

  assign en       = en_reg;
  assign pwr_ok   = pwr_ok_reg;
  assign busy     = busy_reg;
  assign fault    = fault_reg;
  assign flt_idx  = flt_idx_reg;
  assign flt_type = flt_type_reg;
  assign warn     = warn_reg;

endmodule
